mesm6_memory: RTL

Memory responder for the mesm6 core bus: it services the core's `mem_read`/`mem_write` requests against an on-chip word-addressed RAM of 48-bit words and signals completion with a one-cycle `mem_done` pulse. It sits directly on the core's memory port. It implements BESM-6 address-0 semantics and an optional programmable wait-state stretch.

---
 rtl/mesm6_mem_pkg.sv | 14 +
 rtl/mesm6_ram.sv | 24 ++
 rtl/mesm6_memory.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mesm6_mem_pkg.sv
// Shared widths and FSM state type for the mesm6 memory responder.
package mesm6_mem_pkg;

   localparam int WORD_WIDTH = 48;
   localparam int ADDR_WIDTH = 15;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      DONE
   } mem_state_t;

endpackage

// File: rtl/mesm6_ram.sv
// Single-port synchronous RAM, 2**DEPTH_LOG2 x 48, registered read, no reset.
module mesm6_ram
   import mesm6_mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 15
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WORD_WIDTH-1:0] wdata,
   output logic [WORD_WIDTH-1:0] rdata
);

   logic [WORD_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      if (re)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/mesm6_memory.sv
// Memory responder for the mesm6 core bus with BESM-6 address-0 semantics.
// Define MESM6_MEM_WAIT_EN to compile in the WAIT_STATES wait-state stretch.
module mesm6_memory
   import mesm6_mem_pkg::*;
#(
   parameter int DEPTH_LOG2  = 15,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [WORD_WIDTH-1:0] mem_data_write,
   output logic                  mem_done,
   output logic [WORD_WIDTH-1:0] mem_data_read,
   output logic                  bus_error
);

   if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > ADDR_WIDTH ||
       WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_cfg
      $error("mesm6_memory: parameter out of range");
   end

   mem_state_t state_q, state_d;

   logic [DEPTH_LOG2-1:0] addr_q;
   logic [WORD_WIDTH-1:0] wdata_q;
   logic [WORD_WIDTH-1:0] ram_q;
   logic                  wr_q;
   logic                  zero_q;
   logic                  done_q;
   logic                  rd_zero_q;
   logic                  err_q;

   logic addr_zero;
   logic held;
   logic capture;
   logic rd_done;
   logic ram_we;
   logic ram_re;

`ifdef MESM6_MEM_WAIT_EN
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
   logic [3:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
`endif

   // Address 0 and anything past the implemented depth never touch the RAM.
   assign addr_zero = (mem_addr == '0) ||
                      ((mem_addr >> DEPTH_LOG2) != '0);

   // Both strobes high is treated as a write, so follow mem_write then.
   assign held = wr_q ? mem_write : mem_read;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      rd_done = 1'b0;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
`ifdef MESM6_MEM_WAIT_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               capture = 1'b1;
`ifdef MESM6_MEM_WAIT_EN
               if (WAIT_CNT != 4'd0) begin
                  state_d = WAIT;
                  cnt_d   = WAIT_CNT;
               end else begin
                  state_d = ACCESS;
               end
`else
               state_d = ACCESS;
`endif
            end
         end
`ifdef MESM6_MEM_WAIT_EN
         WAIT: begin
            if (!held) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q <= 4'd1) begin
               state_d = ACCESS;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         ACCESS: begin
            if (!held) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
               rd_done = !wr_q;
               ram_we  = wr_q && !zero_q;
               ram_re  = !wr_q && !zero_q;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         zero_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_zero_q <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_d == DONE);
         if (capture) begin
            addr_q  <= mem_addr[DEPTH_LOG2-1:0];
            wdata_q <= mem_data_write;
            wr_q    <= mem_write;
            zero_q  <= addr_zero;
            err_q   <= err_q | (mem_read & mem_write);
         end
         if (rd_done)
            rd_zero_q <= zero_q;
      end
   end

   mesm6_ram #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .re   (ram_re),
      .addr (addr_q),
      .wdata(wdata_q),
      .rdata(ram_q)
   );

   // Both terms only change on a read access, so the output holds otherwise.
   assign mem_data_read = rd_zero_q ? '0 : ram_q;
   assign mem_done      = done_q;
   assign bus_error     = err_q;

endmodule
